// File: rtl/key_schedule_ctrl_pkg.sv
// rtl/key_schedule_ctrl_pkg.sv - AES key-schedule constants, FSM encoding and GF(2^8) helpers
package key_schedule_ctrl_pkg;

    localparam logic [1:0] KEY_128 = 2'b00;
    localparam logic [1:0] KEY_192 = 2'b01;
    localparam logic [1:0] KEY_256 = 2'b10;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CALC    = 2'b01,
        ST_PRESENT = 2'b10
    } ks_state_e;

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            KEY_128: return NR_128;
            KEY_192: return NR_192;
            default: return NR_256;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [1:0] mod3(input logic [3:0] r);
        return 2'(r % 4'd3);
    endfunction

endpackage

// File: rtl/key_schedule_ctrl_key_expansion.sv
// rtl/key_schedule_ctrl_key_expansion.sv - combinational AES expansion step: round key and next state
module key_schedule_ctrl_key_expansion
    import key_schedule_ctrl_pkg::*;
(
    input  logic [255:0] i_exp_key,
    input  logic [3:0]   i_round_times,
    input  logic [1:0]   i_key_mode,
    output logic [127:0] o_round_key,
    output logic [255:0] o_exp_key
);

    // pw[0] is the oldest word of the current block, nw the block that follows it
    logic [0:7][31:0] pw;
    logic [0:7][31:0] nw;
    logic [31:0]      last_w;
    logic [3:0]       rcon_idx;
    logic [1:0]       ph;

    always_comb begin
        pw       = i_exp_key;
        last_w   = 32'h0;
        rcon_idx = 4'd0;
        ph       = 2'd0;
        case (i_key_mode)
            KEY_128: begin
                pw       = {i_exp_key[127:0], 128'h0};
                last_w   = pw[3];
                rcon_idx = i_round_times + 4'd1;
            end
            KEY_192: begin
                pw       = {i_exp_key[191:0], 64'h0};
                last_w   = pw[5];
                ph       = mod3(i_round_times);
                rcon_idx = i_round_times - i_round_times / 4'd3;
            end
            default: begin
                last_w   = pw[7];
                rcon_idx = (i_round_times + 4'd1) >> 1;
            end
        endcase

        nw[0] = pw[0] ^ sub_word(rot_word(last_w)) ^ {rcon_of(rcon_idx), 24'h0};
        nw[1] = pw[1] ^ nw[0];
        nw[2] = pw[2] ^ nw[1];
        nw[3] = pw[3] ^ nw[2];
        nw[4] = pw[4] ^ (i_key_mode[1] ? sub_word(nw[3]) : nw[3]);
        nw[5] = pw[5] ^ nw[4];
        nw[6] = pw[6] ^ nw[5];
        nw[7] = pw[7] ^ nw[6];

        // 192-bit keys cycle through three round-key alignments per two 6-word blocks
        o_exp_key   = i_exp_key;
        o_round_key = pw[0:3];
        case (i_key_mode)
            KEY_128: begin
                o_exp_key = {i_exp_key[255:128], nw[0:3]};
            end
            KEY_192: begin
                case (ph)
                    2'd0: o_round_key = pw[0:3];
                    2'd1: begin
                        o_round_key = {pw[4], pw[5], nw[0], nw[1]};
                        o_exp_key   = {i_exp_key[255:192], nw[0:5]};
                    end
                    default: begin
                        o_round_key = pw[2:5];
                        o_exp_key   = {i_exp_key[255:192], nw[0:5]};
                    end
                endcase
            end
            default: begin
                if (i_round_times[0]) begin
                    o_round_key = pw[4:7];
                    o_exp_key   = nw;
                end
            end
        endcase
    end

endmodule

// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - sequences the key-expansion datapath to stream AES round keys 0..Nr
module key_schedule_ctrl
    import key_schedule_ctrl_pkg::*;
(
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic         i_Start,
    input  logic         i_Abort,
    input  logic [255:0] i_Key,
    input  logic [1:0]   i_Key_Mode,
    output logic [127:0] o_Rkey,
    output logic [3:0]   o_Rkey_Idx,
    output logic         o_Rkey_Valid,
    input  logic         i_Rkey_Ready,
    output logic         o_Rkey_Last,
    output logic         o_Busy,
    output logic         o_Done
);

    ks_state_e    state_q, state_d;
    logic [255:0] exp_key_q, exp_key_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   mode_q, mode_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   rkey_idx_q, rkey_idx_d;
    logic         valid_q, valid_d;
    logic         last_q, last_d;
    logic         done_q, done_d;

    logic [127:0] round_key;
    logic [255:0] next_exp_key;
    logic [3:0]   nr;

    assign nr = nr_of(mode_q);

    key_schedule_ctrl_key_expansion u_key_expansion (
        .i_exp_key     (exp_key_q),
        .i_round_times (round_q),
        .i_key_mode    (mode_q),
        .o_round_key   (round_key),
        .o_exp_key     (next_exp_key)
    );

    always_comb begin
        state_d    = state_q;
        exp_key_d  = exp_key_q;
        round_d    = round_q;
        mode_d     = mode_q;
        rkey_d     = rkey_q;
        rkey_idx_d = rkey_idx_q;
        valid_d    = valid_q;
        last_d     = last_q;
        done_d     = 1'b0;
        // Abort wins over start and handshake; the last presented key stays visible
        if (i_Abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_Start) begin
                        exp_key_d = i_Key;
                        mode_d    = i_Key_Mode;
                        round_d   = 4'd0;
                        state_d   = ST_CALC;
                    end
                end
                ST_CALC: begin
                    rkey_d     = round_key;
                    rkey_idx_d = round_q;
                    last_d     = (round_q == nr);
                    valid_d    = 1'b1;
                    state_d    = ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (i_Rkey_Ready) begin
                        valid_d = 1'b0;
                        if (round_q == nr) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            exp_key_d = next_exp_key;
                            round_d   = round_q + 4'd1;
                            state_d   = ST_CALC;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= ST_IDLE;
            exp_key_q  <= '0;
            round_q    <= '0;
            mode_q     <= KEY_128;
            rkey_q     <= '0;
            rkey_idx_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_key_q  <= exp_key_d;
            round_q    <= round_d;
            mode_q     <= mode_d;
            rkey_q     <= rkey_d;
            rkey_idx_q <= rkey_idx_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            done_q     <= done_d;
        end
    end

    assign o_Rkey       = rkey_q;
    assign o_Rkey_Idx   = rkey_idx_q;
    assign o_Rkey_Valid = valid_q;
    assign o_Rkey_Last  = last_q;
    assign o_Done       = done_q;
    assign o_Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - self-checking bench for key_schedule_ctrl against a word-array AES model
module tb_key_schedule_ctrl;

    logic         i_Clk;
    logic         i_Rst_n;
    logic         i_Start;
    logic         i_Abort;
    logic [255:0] i_Key;
    logic [1:0]   i_Key_Mode;
    logic [127:0] o_Rkey;
    logic [3:0]   o_Rkey_Idx;
    logic         o_Rkey_Valid;
    logic         i_Rkey_Ready;
    logic         o_Rkey_Last;
    logic         o_Busy;
    logic         o_Done;

    key_schedule_ctrl dut (
        .i_Clk        (i_Clk),
        .i_Rst_n      (i_Rst_n),
        .i_Start      (i_Start),
        .i_Abort      (i_Abort),
        .i_Key        (i_Key),
        .i_Key_Mode   (i_Key_Mode),
        .o_Rkey       (o_Rkey),
        .o_Rkey_Idx   (o_Rkey_Idx),
        .o_Rkey_Valid (o_Rkey_Valid),
        .i_Rkey_Ready (i_Rkey_Ready),
        .o_Rkey_Last  (o_Rkey_Last),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [255:0] key;
        logic [1:0]   mode;
        int           idx;
        logic [127:0] rkey;
        logic         last;
    } vec_t;

    localparam logic [255:0] K128 = 256'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [255:0] K192 = 256'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] exp_rk [15];
    int           exp_nr;
    logic [127:0] got_rk [16];
    logic [3:0]   got_idx [16];
    logic         got_last [16];
    int           got_n;
    vec_t         vecs [9];

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // S-box built by walking generator 3 and its inverse, then the affine map
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] key, input logic [1:0] mode);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [255:0] kk;
        int           nk;
        nk     = (mode == 2'd0) ? 4 : (mode == 2'd1) ? 6 : 8;
        exp_nr = nk + 6;
        kk     = key << (32 * (8 - nk));
        for (int i = 0; i < nk; i++) begin
            w[i] = kk[255:224];
            kk   = kk << 32;
        end
        for (int i = nk; i < 4 * (exp_nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / nk; j++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                t = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_w(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= exp_nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
        return v;
    endfunction

    // One full schedule; noise pulses i_Start and scrambles i_Key/i_Key_Mode while busy.
    task automatic run_sched(input logic [255:0] key, input logic [1:0] mode,
                             input int unsigned ready_pct, input bit noise);
        int           cycles;
        bit           stall;
        bit           early_done;
        bit           rdy;
        logic [127:0] hold_rk;
        logic [3:0]   hold_idx;
        model_expand(key, mode);
        @(negedge i_Clk);
        i_Start      = 1'b1;
        i_Key        = key;
        i_Key_Mode   = mode;
        i_Rkey_Ready = 1'b0;
        @(negedge i_Clk);
        i_Start = 1'b0;
        check("start_valid_low", 128'(o_Rkey_Valid), 128'd0);
        check("start_busy", 128'(o_Busy), 128'd1);
        got_n      = 0;
        cycles     = 0;
        stall      = 1'b0;
        early_done = 1'b0;
        hold_rk    = '0;
        hold_idx   = '0;
        while (got_n <= exp_nr && cycles < 200) begin
            @(negedge i_Clk);
            cycles++;
            if (noise) begin
                i_Start    = ($urandom_range(0, 2) == 0);
                i_Key      = rand256();
                i_Key_Mode = 2'($urandom_range(0, 3));
            end
            if (o_Done) early_done = 1'b1;
            if (cycles == 1) check("first_key_latency", 128'(o_Rkey_Valid), 128'd1);
            if (stall) begin
                check("hold_rkey", o_Rkey, hold_rk);
                check("hold_idx", 128'(o_Rkey_Idx), 128'(hold_idx));
                check("hold_valid", 128'(o_Rkey_Valid), 128'd1);
            end
            rdy          = ($urandom_range(0, 99) < ready_pct);
            i_Rkey_Ready = rdy;
            stall        = o_Rkey_Valid && !rdy;
            hold_rk      = o_Rkey;
            hold_idx     = o_Rkey_Idx;
            if (o_Rkey_Valid && rdy) begin
                got_rk[got_n]   = o_Rkey;
                got_idx[got_n]  = o_Rkey_Idx;
                got_last[got_n] = o_Rkey_Last;
                got_n++;
            end
        end
        @(negedge i_Clk);
        i_Start      = 1'b0;
        i_Rkey_Ready = 1'b0;
        check("done_pulse", 128'(o_Done), 128'd1);
        check("valid_after_last", 128'(o_Rkey_Valid), 128'd0);
        check("busy_after_last", 128'(o_Busy), 128'd0);
        @(negedge i_Clk);
        check("done_one_cycle", 128'(o_Done), 128'd0);
        check("no_early_done", 128'(early_done), 128'd0);
        check("key_count", 128'(got_n), 128'(exp_nr + 1));
        if (ready_pct == 100) check("cycles_per_schedule", 128'(cycles), 128'(2 * exp_nr + 1));
        for (int k = 0; k < got_n; k++) begin
            check($sformatf("rkey[%0d]", k), got_rk[k], exp_rk[k]);
            check($sformatf("idx[%0d]", k), 128'(got_idx[k]), 128'(k));
            check($sformatf("last[%0d]", k), 128'(got_last[k]), 128'(k == exp_nr));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cycles;
        build_sbox();
        vecs[0] = '{K128, 2'd0, 0,  128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 1'b0};
        vecs[1] = '{K128, 2'd0, 1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605, 1'b0};
        vecs[2] = '{K128, 2'd0, 10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 1'b1};
        vecs[3] = '{K192, 2'd1, 0,  128'h8e73b0f7_da0e6452_c810f32b_809079e5, 1'b0};
        vecs[4] = '{K192, 2'd1, 12, 128'he98ba06f_448c773c_8ecc7204_01002202, 1'b1};
        vecs[5] = '{K256, 2'd2, 0,  128'h603deb10_15ca71be_2b73aef0_857d7781, 1'b0};
        vecs[6] = '{K256, 2'd2, 1,  128'h1f352c07_3b6108d7_2d9810a3_0914dff4, 1'b0};
        vecs[7] = '{K256, 2'd2, 14, 128'hfe4890d1_e6188d0b_046df344_706c631e, 1'b1};
        vecs[8] = '{K256, 2'd3, 14, 128'hfe4890d1_e6188d0b_046df344_706c631e, 1'b1};

        i_Rst_n      = 1'b0;
        i_Start      = 1'b0;
        i_Abort      = 1'b0;
        i_Key        = '0;
        i_Key_Mode   = 2'd0;
        i_Rkey_Ready = 1'b0;
        repeat (2) @(negedge i_Clk);
        check("reset_rkey", o_Rkey, 128'd0);
        check("reset_idx", 128'(o_Rkey_Idx), 128'd0);
        check("reset_valid", 128'(o_Rkey_Valid), 128'd0);
        check("reset_last", 128'(o_Rkey_Last), 128'd0);
        check("reset_busy", 128'(o_Busy), 128'd0);
        check("reset_done", 128'(o_Done), 128'd0);
        i_Rst_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            run_sched(vecs[v].key, vecs[v].mode, 100, 1'b0);
            check($sformatf("vec%0d_rkey", v), got_rk[vecs[v].idx], vecs[v].rkey);
            check($sformatf("vec%0d_last", v), 128'(got_last[vecs[v].idx]), 128'(vecs[v].last));
        end

        run_sched(K128, 2'd0, 30, 1'b1);
        run_sched(K192, 2'd1, 30, 1'b1);
        run_sched(K256, 2'd2, 30, 1'b1);

        // Abort while idx5 is presented, with ready high at the same edge
        model_expand(K128, 2'd0);
        @(negedge i_Clk);
        i_Start      = 1'b1;
        i_Key        = K128;
        i_Key_Mode   = 2'd0;
        i_Rkey_Ready = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        cycles  = 0;
        while (!(o_Rkey_Valid && o_Rkey_Idx == 4'd5) && cycles < 100) begin
            @(negedge i_Clk);
            cycles++;
        end
        check("abort_reach_idx5", 128'(o_Rkey_Idx), 128'd5);
        i_Abort = 1'b1;
        @(negedge i_Clk);
        i_Abort      = 1'b0;
        i_Rkey_Ready = 1'b0;
        check("abort_busy", 128'(o_Busy), 128'd0);
        check("abort_valid", 128'(o_Rkey_Valid), 128'd0);
        check("abort_done", 128'(o_Done), 128'd0);
        check("abort_rkey_kept", o_Rkey, exp_rk[5]);
        @(negedge i_Clk);
        check("abort_no_done_later", 128'(o_Done), 128'd0);

        // Asynchronous reset in the middle of a 256-bit schedule, then restart
        @(negedge i_Clk);
        i_Start      = 1'b1;
        i_Key        = K256;
        i_Key_Mode   = 2'd2;
        i_Rkey_Ready = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        repeat (7) @(negedge i_Clk);
        i_Rst_n = 1'b0;
        #1;
        check("midrst_rkey", o_Rkey, 128'd0);
        check("midrst_idx", 128'(o_Rkey_Idx), 128'd0);
        check("midrst_valid", 128'(o_Rkey_Valid), 128'd0);
        check("midrst_last", 128'(o_Rkey_Last), 128'd0);
        check("midrst_busy", 128'(o_Busy), 128'd0);
        check("midrst_done", 128'(o_Done), 128'd0);
        @(negedge i_Clk);
        i_Rst_n      = 1'b1;
        i_Rkey_Ready = 1'b0;
        run_sched(K128, 2'd0, 100, 1'b0);

        for (int t = 0; t < 6; t++) begin
            run_sched(rand256(), 2'($urandom_range(0, 3)), 30 + 10 * t, t[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
